j17_control: RTL and testbench

Multi-cycle control unit for the J17 core: fetches 32-bit instruction words over a request/ready handshake, decodes them, and sequences the control bundle consumed by the datapath (ALU code, operand selects, register/RAM enables, PC control). It is the initiator side of the datapath's control interface. It also owns instruction retirement counting, halt, and illegal-instruction trap.

---
 rtl/j17_pkg.sv | 23 ++
 rtl/j17_if.sv | 20 ++
 rtl/j17_decoder.sv | 31 +++
 rtl/j17_control.sv | 73 +++++++
 tb/tb_j17_control.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/j17_pkg.sv
// j17_pkg: shared J17 opcodes, field encodings, FSM states, instruction classes and control-bundle type
package j17_pkg;
  localparam logic [4:0] OP_MOV = 5'd12, OP_LOAD = 5'd13, OP_STORE = 5'd14;
  localparam logic [4:0] OP_BR_LO = 5'd16, OP_BR_HI = 5'd22, OP_HALT = 5'd23;
  localparam logic [1:0] MODE_REG = 2'b00, MODE_IMM = 2'b01, MODE_MEM = 2'b10, MODE_ILL = 2'b11;
  localparam logic [1:0] RAM_OFF = 2'b00, RAM_RD = 2'b01, RAM_WR = 2'b10;
  localparam logic [1:0] WR_ALU = 2'd0, WR_OP2 = 2'd1;
  localparam logic [2:0] PC_STEP = 3'd0;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP} state_e;
  typedef enum logic [2:0] {K_ALU, K_MOV, K_LOAD, K_STORE, K_BR, K_HALT, K_ILL} kind_e;
  typedef struct packed {
    logic [4:0]  alucode;
    logic [4:0]  op1;
    logic [19:0] op2;
    logic        imcontrol;
    logic        flag;
    logic        regenable;
    logic [1:0]  ramenable;
    logic [1:0]  writecode;
    logic [2:0]  pccontrol;
    logic        pcstep;
  } ctrl_t;
endpackage

// File: rtl/j17_if.sv
// j17_if: fetch handshake (imem_req/imem_ready/instr) plus datapath control bundle; master = control unit
interface j17_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] instr;
  logic [4:0]  alucode;
  logic [4:0]  op1;
  logic [19:0] op2;
  logic        imControl;
  logic        flag;
  logic        regenable;
  logic [1:0]  ramenable;
  logic [1:0]  writecode;
  logic [2:0]  pcControl;
  logic        pcstep;
  modport master(output imem_req, alucode, op1, op2, imControl, flag, regenable, ramenable, writecode, pcControl, pcstep,
                 input imem_ready, instr);
  modport slave(input imem_req, alucode, op1, op2, imControl, flag, regenable, ramenable, writecode, pcControl, pcstep,
                output imem_ready, instr);
endinterface

// File: rtl/j17_decoder.sv
// j17_decoder: combinational instr word -> class (o_kind) and execute-cycle control bundle (o_ctrl)
module j17_decoder
  import j17_pkg::*;
(
  input  logic [31:0] i_instr,
  output kind_e       o_kind,
  output ctrl_t       o_ctrl
);
  logic [4:0] w_opc;
  logic [1:0] w_mode;
  assign w_opc  = i_instr[31:27];
  assign w_mode = i_instr[26:25];
  always_comb begin
    o_kind = w_mode == MODE_ILL ? K_ILL :
             w_opc < OP_MOV ? K_ALU :
             w_opc == OP_MOV ? K_MOV :
             w_opc == OP_LOAD ? K_LOAD :
             w_opc == OP_STORE ? K_STORE :
             (w_opc >= OP_BR_LO && w_opc <= OP_BR_HI) ? K_BR :
             w_opc == OP_HALT ? K_HALT : K_ILL;
    o_ctrl           = '0;
    o_ctrl.alucode   = o_kind == K_ALU ? w_opc : 5'd0;
    o_ctrl.op1       = i_instr[24:20];
    o_ctrl.op2       = i_instr[19:0];
    o_ctrl.regenable = o_kind == K_ALU || o_kind == K_MOV;
    o_ctrl.imcontrol = o_ctrl.regenable && w_mode != MODE_REG;
    o_ctrl.writecode = o_kind == K_MOV ? WR_OP2 : WR_ALU;
    o_ctrl.pccontrol = o_kind == K_BR ? 3'(w_opc - 5'd15) : PC_STEP;
    o_ctrl.pcstep    = 1'b1;
  end
endmodule

// File: rtl/j17_control.sv
// j17_control: multi-cycle J17 fetch/decode/sequence FSM; ports clock, resetn (sync low), bus (j17_if.master), retired/halted/trap status
module j17_control
  import j17_pkg::*;
#(
  parameter int RETIRE_W      = 32,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                resetn,
  j17_if.master               bus,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                trap
);
  state_e              r_state, w_next;
  logic [31:0]         r_instr;
  logic [15:0]         r_wait;
  logic [RETIRE_W-1:0] r_retired;
  kind_e               w_kind;
  ctrl_t               w_dec, w_out;
  j17_decoder u_dec (.i_instr(r_instr), .o_kind(w_kind), .o_ctrl(w_dec));
  always_ff @(posedge clock)
    if (!resetn) begin
      r_state   <= S_FETCH;
      r_instr   <= '0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= r_state == S_FETCH && !bus.imem_ready ? r_wait + 16'd1 : 16'd0;
      r_instr   <= r_state == S_FETCH && bus.imem_ready ? bus.instr : r_instr;
      r_retired <= r_retired + RETIRE_W'(w_out.pcstep);
    end
  always_comb
    case (r_state)
      S_FETCH:  w_next = bus.imem_ready ? S_DECODE : r_wait == 16'(FETCH_TIMEOUT - 1) ? S_TRAP : S_FETCH;
      S_DECODE: w_next = w_kind == K_ILL ? S_TRAP : w_kind == K_HALT ? S_HALT :
                         (w_kind == K_LOAD || w_kind == K_STORE) ? S_MEM : S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_MEM:    w_next = w_kind == K_LOAD ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  // resetn low blanks every strobe so an aborted instruction shows nothing in the reset cycle
  always_comb begin
    w_out = '0;
    if (resetn && r_state == S_EXEC) w_out = w_dec;
    if (resetn && (r_state == S_MEM || r_state == S_WB)) begin
      w_out.op1       = w_dec.op1;
      w_out.op2       = w_dec.op2;
      w_out.imcontrol = 1'b1;
      w_out.ramenable = r_state == S_MEM && w_kind == K_STORE ? RAM_WR : RAM_RD;
      w_out.pcstep    = r_state == S_WB || w_kind == K_STORE;
      w_out.flag      = r_state == S_WB;
      w_out.regenable = r_state == S_WB;
      w_out.writecode = r_state == S_WB ? WR_OP2 : WR_ALU;
    end
  end
  assign bus.imem_req  = resetn && r_state == S_FETCH;
  assign bus.alucode   = w_out.alucode;
  assign bus.op1       = w_out.op1;
  assign bus.op2       = w_out.op2;
  assign bus.imControl = w_out.imcontrol;
  assign bus.flag      = w_out.flag;
  assign bus.regenable = w_out.regenable;
  assign bus.ramenable = w_out.ramenable;
  assign bus.writecode = w_out.writecode;
  assign bus.pcControl = w_out.pccontrol;
  assign bus.pcstep    = w_out.pcstep;
  assign retired       = r_retired;
  assign halted        = r_state == S_HALT;
  assign trap          = r_state == S_TRAP;
endmodule

// File: tb/tb_j17_control.sv
// tb_j17_control: vector table + retire scoreboard for j17_control, with hand sequences for load, trap, timeout, halt and reset abort
module tb_j17_control;
  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic [4:0]  alu;
    logic [2:0]  pcc;
    logic        reg_en;
    logic [1:0]  wc;
    logic        imc;
    logic [1:0]  ram;
    logic        flg;
    int          lat;
  } vec_t;
  logic        clk = 0;
  logic        resetn;
  logic [31:0] retired;
  logic        halted, trap;
  int          n_chk = 0, n_err = 0;
  int          exp_ret = 0;
  vec_t        tab[13];
  vec_t        exp_q[$];
  vec_t        m_e;
  j17_if bus ();
  j17_control #(.RETIRE_W(32), .FETCH_TIMEOUT(8)) dut (
    .clock(clk), .resetn(resetn), .bus(bus), .retired(retired), .halted(halted), .trap(trap));
  always #5 clk = ~clk;
  function automatic logic [31:0] enc(input logic [4:0] op, input logic [1:0] m, input logic [4:0] r, input logic [19:0] o);
    return {op, m, r, o};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (bus.pcstep === 1'b1) begin
      if (exp_q.size() == 0) chk("pcstep_unexpected", 32'(bus.pcstep), 0);
      else begin
        m_e = exp_q.pop_front();
        chk("alucode", 32'(bus.alucode), 32'(m_e.alu));
        chk("pcControl", 32'(bus.pcControl), 32'(m_e.pcc));
        chk("regenable", 32'(bus.regenable), 32'(m_e.reg_en));
        chk("writecode", 32'(bus.writecode), 32'(m_e.wc));
        chk("imControl", 32'(bus.imControl), 32'(m_e.imc));
        chk("ramenable", 32'(bus.ramenable), 32'(m_e.ram));
        chk("flag", 32'(bus.flag), 32'(m_e.flg));
        chk("op1", 32'(bus.op1), 32'(m_e.instr[24:20]));
        chk("op2", 32'(bus.op2), 32'(m_e.instr[19:0]));
        chk("retired_at_pcstep", retired, 32'(exp_ret));
        exp_ret++;
      end
    end
  task automatic fetch(input logic [31:0] w, input int d);
    int n = 0;
    for (int i = 0; i <= d; i++) begin
      bus.imem_ready = i == d;
      bus.instr      = i == d ? w : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus.imem_req === 1'b1) n++;
      @(posedge clk);
      #1;
    end
    bus.imem_ready = 0;
    bus.instr      = 32'hFFFF_FFFF;
    chk("imem_req_cycles", 32'(n), 32'(d + 1));
  endtask
  task automatic wait_retire(input int lat);
    int  n    = 0;
    bit  seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = bus.pcstep === 1'b1;
    end
    chk("latency", seen ? 32'(n + 1) : 32'hFFFF_FFFF, 32'(lat));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 0;
    @(posedge clk);
    #1;
    exp_ret = 0;
    @(negedge clk);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", retired, 0);
    @(posedge clk);
    #1;
    resetn = 1;
  endtask
  task automatic trap_case(input logic [31:0] w);
    fetch(w, 0);
    @(negedge clk);
    @(negedge clk);
    chk("trap_set", 32'(trap), 1);
    chk("trap_req", 32'(bus.imem_req), 0);
    chk("trap_regen", 32'(bus.regenable), 0);
    chk("trap_retired", retired, 32'(exp_ret));
    bus.imem_ready = 1;
    bus.instr      = enc(1, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("trap_sticky", 32'(trap), 1);
    chk("trap_req_sticky", 32'(bus.imem_req), 0);
    bus.imem_ready = 0;
    do_reset();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    tab[0]  = '{enc(1, 0, 3, 20'h0A000), 0, 5'd1, 3'd0, 1, 2'd0, 0, 2'd0, 0, 3};
    tab[1]  = '{enc(2, 1, 5, 20'h12345), 2, 5'd2, 3'd0, 1, 2'd0, 1, 2'd0, 0, 3};
    tab[2]  = '{enc(11, 0, 31, 20'hFFFFF), 0, 5'd11, 3'd0, 1, 2'd0, 0, 2'd0, 0, 3};
    tab[3]  = '{enc(0, 2, 1, 20'h00001), 1, 5'd0, 3'd0, 1, 2'd0, 1, 2'd0, 0, 3};
    tab[4]  = '{enc(12, 1, 7, 20'h000FF), 0, 5'd0, 3'd0, 1, 2'd1, 1, 2'd0, 0, 3};
    tab[5]  = '{enc(13, 2, 4, 20'h00040), 0, 5'd0, 3'd0, 1, 2'd1, 1, 2'b01, 1, 4};
    tab[6]  = '{enc(14, 2, 6, 20'h00080), 3, 5'd0, 3'd0, 0, 2'd0, 1, 2'b10, 0, 3};
    tab[7]  = '{enc(16, 1, 0, 20'h00100), 0, 5'd0, 3'd1, 0, 2'd0, 0, 2'd0, 0, 3};
    tab[8]  = '{enc(17, 1, 0, 20'h00200), 5, 5'd0, 3'd2, 0, 2'd0, 0, 2'd0, 0, 3};
    tab[9]  = '{enc(19, 0, 2, 20'h0A400), 0, 5'd0, 3'd4, 0, 2'd0, 0, 2'd0, 0, 3};
    tab[10] = '{enc(22, 1, 0, 20'h00300), 0, 5'd0, 3'd7, 0, 2'd0, 0, 2'd0, 0, 3};
    tab[11] = '{enc(1, 1, 9, 20'h00005), 7, 5'd1, 3'd0, 1, 2'd0, 1, 2'd0, 0, 3};
    tab[12] = '{enc(21, 0, 0, 20'h00400), 0, 5'd0, 3'd6, 0, 2'd0, 0, 2'd0, 0, 3};
    resetn = 0;
    bus.imem_ready = 0;
    bus.instr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", 32'(bus.imem_req), 0);
    chk("reset_pcstep", 32'(bus.pcstep), 0);
    chk("reset_regen", 32'(bus.regenable), 0);
    chk("reset_ram", 32'(bus.ramenable), 0);
    chk("reset_pcc", 32'(bus.pcControl), 0);
    chk("reset_alu", 32'(bus.alucode), 0);
    chk("reset_retired", retired, 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_trap", 32'(trap), 0);
    @(posedge clk);
    #1;
    resetn = 1;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(tab[i]);
      fetch(tab[i].instr, tab[i].delay);
      wait_retire(tab[i].lat);
    end
    exp_q.push_back(tab[5]);
    fetch(tab[5].instr, 0);
    @(negedge clk);
    chk("load_decode_ram", 32'(bus.ramenable), 0);
    @(negedge clk);
    chk("load_mem_ram", 32'(bus.ramenable), 1);
    chk("load_mem_imc", 32'(bus.imControl), 1);
    chk("load_mem_pcstep", 32'(bus.pcstep), 0);
    chk("load_mem_regen", 32'(bus.regenable), 0);
    chk("load_mem_flag", 32'(bus.flag), 0);
    @(negedge clk);
    chk("load_wb_pcstep", 32'(bus.pcstep), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("retired_total", retired, 14);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    trap_case(enc(31, 0, 0, 0));
    trap_case(enc(1, 3, 2, 20'h00010));
    trap_case(enc(15, 0, 0, 0));
    n = 0;
    for (int i = 0; i < 20 && trap !== 1'b1; i++) begin
      @(negedge clk);
      if (trap !== 1'b1 && bus.imem_req === 1'b1) n++;
    end
    chk("timeout_cycles", 32'(n), 8);
    chk("timeout_trap", 32'(trap), 1);
    do_reset();
    fetch(enc(23, 0, 0, 0), 0);
    @(negedge clk);
    @(negedge clk);
    chk("halt_set", 32'(halted), 1);
    chk("halt_req", 32'(bus.imem_req), 0);
    chk("halt_no_trap", 32'(trap), 0);
    bus.imem_ready = 1;
    bus.instr = tab[0].instr;
    repeat (3) @(negedge clk);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_req_sticky", 32'(bus.imem_req), 0);
    bus.imem_ready = 0;
    do_reset();
    fetch(tab[6].instr, 0);
    @(posedge clk);
    #1;
    resetn = 0;
    @(negedge clk);
    chk("abort_pcstep", 32'(bus.pcstep), 0);
    chk("abort_ram", 32'(bus.ramenable), 0);
    @(posedge clk);
    #1;
    exp_ret = 0;
    resetn = 1;
    @(negedge clk);
    chk("abort_retired", retired, 0);
    chk("abort_refetch", 32'(bus.imem_req), 1);
    @(posedge clk);
    #1;
    exp_q.push_back(tab[0]);
    fetch(tab[0].instr, 0);
    wait_retire(tab[0].lat);
    @(negedge clk);
    chk("abort_then_retired", retired, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
